// File: rtl/alu_unit.sv
// Registered N-bit ALU: add/sub/mul/div/mod computed in parallel, opcode-selected result plus side outputs.
// Optional ALU_FLAGS_EN adds registered zero_flag/neg_flag derived from the selected result.
module alu_unit #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [2:0]       op,
    input  logic             op_sum,
    input  logic             op_subt,
    output logic [N-1:0]     result,
    output logic [N-1:0]     sumResult,
    output logic [N-1:0]     subResult,
    output logic [N-1:0]     diviResult,
    output logic [N-1:0]     moduResult,
    output logic [2*N-1:0]   multiResult,
    output logic             carryingSum,
    output logic             carryingSub
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             neg_flag
`endif
);

    logic [2:0]     code;
    logic [N:0]     sum_next;
    logic [N:0]     sub_next;
    logic [2*N-1:0] mul_next;
    logic [N-1:0]   quot_next;
    logic [N-1:0]   rem_next;
    logic [N-1:0]   div_rem;
    logic [N:0]     div_trial;
    logic [N-1:0]   and_bits;
    logic [N-1:0]   or_bits;
    logic [N-1:0]   xor_bits;
    logic [N-1:0]   result_next;

    // Push buttons pull low when pressed, so the working opcode is the inverse.
    assign code     = ~op;
    assign sum_next = {1'b0, a} + {1'b0, b};
    assign sub_next = {1'b0, a} - {1'b0, b};
    assign mul_next = {{N{1'b0}}, a} * {{N{1'b0}}, b};

    for (genvar gi = 0; gi < N; gi++) begin : g_logic_lane
        assign and_bits[gi] = a[gi] & b[gi];
        assign or_bits[gi]  = a[gi] | b[gi];
        assign xor_bits[gi] = a[gi] ^ b[gi];
    end

    // Restoring division, MSB first. With b=0 every trial succeeds, which
    // naturally yields an all-ones quotient and a remainder equal to a.
    always_comb begin
        quot_next = '0;
        div_rem   = '0;
        div_trial = '0;
        for (int i = N - 1; i >= 0; i--) begin
            div_trial = {div_rem, a[i]};
            if (div_trial >= {1'b0, b}) begin
                quot_next[i] = 1'b1;
                div_trial    = div_trial - {1'b0, b};
            end
            div_rem = div_trial[N-1:0];
        end
        rem_next = div_rem;
    end

    always_comb begin
        result_next = sum_next[N-1:0];
        if (op_sum) begin
            result_next = sum_next[N-1:0];
        end else if (op_subt) begin
            result_next = sub_next[N-1:0];
        end else begin
            case (code)
                3'd0: result_next = sum_next[N-1:0];
                3'd1: result_next = sub_next[N-1:0];
                3'd2: result_next = mul_next[N-1:0];
                3'd3: result_next = quot_next;
                3'd4: result_next = rem_next;
                3'd5: result_next = and_bits;
                3'd6: result_next = or_bits;
                default: result_next = xor_bits;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            sumResult   <= '0;
            subResult   <= '0;
            diviResult  <= '0;
            moduResult  <= '0;
            multiResult <= '0;
            carryingSum <= 1'b0;
            carryingSub <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero_flag   <= 1'b0;
            neg_flag    <= 1'b0;
`endif
        end else begin
            result      <= result_next;
            sumResult   <= sum_next[N-1:0];
            subResult   <= sub_next[N-1:0];
            diviResult  <= quot_next;
            moduResult  <= rem_next;
            multiResult <= mul_next;
            carryingSum <= sum_next[N];
            carryingSub <= sub_next[N];
`ifdef ALU_FLAGS_EN
            zero_flag   <= (result_next == '0);
            neg_flag    <= result_next[N-1];
`endif
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit (N=4): arithmetic reference model checked every cycle, plus hand-computed vectors.
module tb_alu_unit;
    localparam int N = 4;
    localparam int M = 1 << N;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2:0]     op;
    logic           op_sum;
    logic           op_subt;
    logic [N-1:0]   result;
    logic [N-1:0]   sumResult;
    logic [N-1:0]   subResult;
    logic [N-1:0]   diviResult;
    logic [N-1:0]   moduResult;
    logic [2*N-1:0] multiResult;
    logic           carryingSum;
    logic           carryingSub;
`ifdef ALU_FLAGS_EN
    logic           zero_flag;
    logic           neg_flag;
`endif

    alu_unit #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (a),
        .b           (b),
        .op          (op),
        .op_sum      (op_sum),
        .op_subt     (op_subt),
        .result      (result),
        .sumResult   (sumResult),
        .subResult   (subResult),
        .diviResult  (diviResult),
        .moduResult  (moduResult),
        .multiResult (multiResult),
        .carryingSum (carryingSum),
        .carryingSub (carryingSub)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    typedef struct packed {
        logic [N-1:0]   res;
        logic [N-1:0]   sum;
        logic [N-1:0]   sub;
        logic [N-1:0]   quo;
        logic [N-1:0]   rem;
        logic [2*N-1:0] mul;
        logic           cs;
        logic           cb;
    } exp_t;

    exp_t exp_q;

    function automatic exp_t model(input int ai, input int bi, input logic [2:0] opc,
                                   input logic fs, input logic fd);
        exp_t x;
        int s, d, p, q, r, sel, e;
        s = ai + bi;
        d = ((ai - bi) % M + M) % M;
        p = ai * bi;
        q = (bi == 0) ? M - 1 : ai / bi;
        r = (bi == 0) ? ai : ai % bi;
        e = 7 - int'(opc);
        case (e)
            0: sel = s % M;
            1: sel = d;
            2: sel = p % M;
            3: sel = q;
            4: sel = r;
            5: sel = ai & bi;
            6: sel = ai | bi;
            default: sel = ai ^ bi;
        endcase
        if (fs) sel = s % M;
        else if (fd) sel = d;
        x.res = N'(sel);
        x.sum = N'(s % M);
        x.sub = N'(d);
        x.quo = N'(q);
        x.rem = N'(r);
        x.mul = (2*N)'(p);
        x.cs  = (s >= M);
        x.cb  = (ai < bi);
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference state: what the registered outputs must hold after each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '0;
        else     exp_q <= model(int'(a), int'(b), op, op_sum, op_subt);
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_result", 64'(result), 64'(exp_q.res));
            check("cmp_sum", 64'(sumResult), 64'(exp_q.sum));
            check("cmp_sub", 64'(subResult), 64'(exp_q.sub));
            check("cmp_div", 64'(diviResult), 64'(exp_q.quo));
            check("cmp_mod", 64'(moduResult), 64'(exp_q.rem));
            check("cmp_mul", 64'(multiResult), 64'(exp_q.mul));
            check("cmp_carry_sum", 64'(carryingSum), 64'(exp_q.cs));
            check("cmp_carry_sub", 64'(carryingSub), 64'(exp_q.cb));
`ifdef ALU_FLAGS_EN
            check("cmp_zero_flag", 64'(zero_flag), 64'(exp_q.res == '0));
            check("cmp_neg_flag", 64'(neg_flag), 64'(exp_q.res[N-1]));
`endif
        end
    end

    task automatic apply(input logic [N-1:0] av, input logic [N-1:0] bv, input logic [2:0] opv,
                         input logic fs, input logic fd);
        @(negedge clk);
        a = av; b = bv; op = opv; op_sum = fs; op_subt = fd;
        @(posedge clk);
        #1;
        $display("vec a=%0d b=%0d op=%b sum=%b subt=%b -> result=%0d mul=%0d", av, bv, opv, fs, fd,
                 result, multiResult);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"}, 64'(result), 64'd0);
        check({tag, "_sum"}, 64'(sumResult), 64'd0);
        check({tag, "_sub"}, 64'(subResult), 64'd0);
        check({tag, "_div"}, 64'(diviResult), 64'd0);
        check({tag, "_mod"}, 64'(moduResult), 64'd0);
        check({tag, "_mul"}, 64'(multiResult), 64'd0);
        check({tag, "_cs"}, 64'(carryingSum), 64'd0);
        check({tag, "_cb"}, 64'(carryingSub), 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pa [5];
        int pb [5];
        pa = '{7, 15, 0, 13, 5};
        pb = '{3, 15, 0, 0, 12};

        rst = 1'b1; a = '0; b = '0; op = 3'b111; op_sum = 1'b0; op_subt = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        #1 cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        apply(4'b1000, 4'b0000, 3'b111, 1'b0, 1'b0);
        check("t1_result", 64'(result), 64'b1000);
        check("t1_carry_sum", 64'(carryingSum), 64'd0);
        check("t1_div0", 64'(diviResult), 64'b1111);
        check("t1_mod0", 64'(moduResult), 64'b1000);

        apply(4'b1001, 4'b1001, 3'b110, 1'b0, 1'b0);
        check("t2_result", 64'(result), 64'd0);
        check("t2_carry_sub", 64'(carryingSub), 64'd0);
        check("t2_mul", 64'(multiResult), 64'b01010001);

        apply(4'b1010, 4'b0010, 3'b101, 1'b0, 1'b0);
        check("t3_mul", 64'(multiResult), 64'b00010100);
        check("t3_result", 64'(result), 64'b0100);
        apply(4'b1010, 4'b0010, 3'b100, 1'b0, 1'b0);
        check("t3_div_result", 64'(result), 64'b0101);

        apply(4'b1011, 4'b1011, 3'b011, 1'b0, 1'b0);
        check("t4_result", 64'(result), 64'd0);
        check("t4_div", 64'(diviResult), 64'b0001);

        apply(4'b1111, 4'b1000, 3'b111, 1'b1, 1'b1);
        check("t5_result", 64'(result), 64'b0111);
        check("t5_carry_sum", 64'(carryingSum), 64'd1);
        check("t5_sub", 64'(subResult), 64'b0111);
        check("t5_carry_sub", 64'(carryingSub), 64'd0);

        apply(4'b0011, 4'b0101, 3'b111, 1'b0, 1'b1);
        check("t6_result", 64'(result), 64'b1110);
        check("t6_carry_sub", 64'(carryingSub), 64'd1);

        // Asynchronous reset in the middle of a cycle, then held across an edge.
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");

        @(negedge clk);
        rst = 1'b0; a = 4'd6; b = 4'd3; op = 3'b101; op_sum = 1'b0; op_subt = 1'b0;
        @(posedge clk);
        #1;
        $display("vec a=6 b=3 op=101 after reset release -> result=%0d mul=%0d", result, multiResult);
        check("rel_result", 64'(result), 64'd2);
        check("rel_mul", 64'(multiResult), 64'd18);

        apply(4'b1100, 4'b1010, 3'b010, 1'b0, 1'b0);
        check("and_result", 64'(result), 64'b1000);
        apply(4'b1100, 4'b1010, 3'b001, 1'b0, 1'b0);
        check("or_result", 64'(result), 64'b1110);
        apply(4'b1100, 4'b1010, 3'b000, 1'b0, 1'b0);
        check("xor_result", 64'(result), 64'b0110);

        for (int k = 0; k < 5; k++) begin
            for (int e = 0; e < 8; e++) begin
                apply(N'(pa[k]), N'(pb[k]), 3'(7 - e), 1'b0, 1'b0);
            end
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
